cpc_gate_array: RTL and testbench

CPC_GATE_ARRAY -- requirements
Module: cpc_gate_array

---
 rtl/cpc_gate_array_if.sv | 12 +
 rtl/cpc_gate_array.sv | 204 ++++++++++++++++++++
 tb/tb_cpc_gate_array.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpc_gate_array_if.sv
// Z80 I/O bus as seen by the CPC gate array: write strobe, address, data,
// interrupt acknowledge and the interrupt request back to the CPU.
interface cpc_gate_array_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        iowr;
  logic        intack;
  logic        irq;

  modport master (output addr, output dout, output iowr, output intack, input irq);
  modport slave  (input addr, input dout, input iowr, input intack, output irq);
endinterface

// File: rtl/cpc_gate_array.sv
// CPC gate array: pen/palette/border, ROM and mode config, CRTC register
// shadow and the 52-line raster interrupt with vsync resynchronisation.
module cpc_gate_array (
  input  logic                   clk,
  input  logic                   rstn,
  cpc_gate_array_if.slave        bus,
  input  logic                   hsyn,
  input  logic                   n64u,
  input  logic                   dvsyn,
  output logic [1:0]             mode,
  output logic [4:0]             border,
  output logic [3:0]             palix,
  output logic [4:0]             paldat,
  output logic                   palwr,
  output logic [5:0]             hmax,
  output logic [4:0]             vmax,
  output logic [15:0]            ma,
  output logic                   lromdis,
  output logic                   uromdis
);

  function automatic logic [5:0] sat_hmax(input logic [7:0] v);
    return (v > 8'd40) ? 6'd40 : v[5:0];
  endfunction

  function automatic logic [4:0] sat_vmax(input logic [7:0] v);
    return (v > 8'd30) ? 5'd30 : v[4:0];
  endfunction

  logic [1:0]  mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic [4:0]  border_q, border_d, paldat_q, paldat_d, crtc_idx_q, crtc_idx_d;
  logic [3:0]  pen_q, pen_d, palix_q, palix_d;
  logic        border_sel_q, border_sel_d, palwr_q, palwr_d;
  logic [5:0]  hmax_q, hmax_d, cnt_q, cnt_d;
  logic [4:0]  vmax_q, vmax_d;
  logic [15:0] ma_q, ma_d;
  logic        lromdis_q, lromdis_d, uromdis_q, uromdis_d, irq_q, irq_d;
  logic        vs_arm_q, vs_arm_d, vs_line_q, vs_line_d;
  logic        hsyn_q, hsyn_d, dvsyn_q, dvsyn_d;
  logic        ga_wr, crtc_wr, irq_set, vs_fire, unused_bits;

  assign unused_bits = ^{bus.addr[13:10], bus.addr[7:0]};

  always_comb begin
    ga_wr        = bus.iowr & (bus.addr[15:14] == 2'b01);
    crtc_wr      = bus.iowr & ~bus.addr[14];
    irq_set      = 1'b0;
    vs_fire      = 1'b0;
    mode_d       = mode_q;
    pend_mode_d  = pend_mode_q;
    border_d     = border_q;
    border_sel_d = border_sel_q;
    pen_d        = pen_q;
    palix_d      = palix_q;
    paldat_d     = paldat_q;
    palwr_d      = 1'b0;
    hmax_d       = hmax_q;
    vmax_d       = vmax_q;
    ma_d         = ma_q;
    crtc_idx_d   = crtc_idx_q;
    lromdis_d    = lromdis_q;
    uromdis_d    = uromdis_q;
    irq_d        = irq_q;
    cnt_d        = cnt_q;
    vs_arm_d     = vs_arm_q;
    vs_line_d    = vs_line_q;
    hsyn_d       = hsyn;
    dvsyn_d      = dvsyn;

    if (ga_wr) begin
      case (bus.dout[7:6])
        2'b00: begin
          if (bus.dout[4]) begin
            border_sel_d = 1'b1;
          end else begin
            pen_d        = bus.dout[3:0];
            border_sel_d = 1'b0;
          end
        end
        2'b01: begin
          if (border_sel_q) begin
            border_d = bus.dout[4:0];
          end else begin
            palix_d  = pen_q;
            paldat_d = bus.dout[4:0];
            palwr_d  = 1'b1;
          end
        end
        2'b10: begin
          lromdis_d   = bus.dout[2];
          uromdis_d   = bus.dout[3];
          pend_mode_d = bus.dout[1:0];
        end
        default: ;
      endcase
    end

    // Mode only switches at the start of a line so a frame never mixes modes mid-line.
    if (hsyn_q & ~hsyn) mode_d = pend_mode_q;

    if (crtc_wr && bus.addr[9:8] == 2'b00) begin
      crtc_idx_d = bus.dout[4:0];
    end else if (crtc_wr && bus.addr[9:8] == 2'b01) begin
      case (crtc_idx_q)
        5'd1:    hmax_d      = sat_hmax(bus.dout);
        5'd6:    vmax_d      = sat_vmax(bus.dout);
        5'd12:   ma_d[15:8]  = bus.dout;
        5'd13:   ma_d[7:0]   = bus.dout;
        default: ;
      endcase
    end

    // A fresh vsync edge restarts the two-line delay; that cycle's line pulse is not counted.
    if (dvsyn & ~dvsyn_q) begin
      vs_arm_d  = 1'b1;
      vs_line_d = 1'b0;
    end else if (n64u & vs_arm_q) begin
      if (vs_line_q) begin
        vs_fire   = 1'b1;
        vs_arm_d  = 1'b0;
        vs_line_d = 1'b0;
      end else begin
        vs_line_d = 1'b1;
      end
    end

    if (n64u) begin
      cnt_d   = (cnt_q == 6'd51 || vs_fire) ? 6'd0 : cnt_q + 6'd1;
      irq_set = (cnt_q == 6'd51) | (vs_fire & cnt_q[5]);
    end
    if (irq_set) irq_d = 1'b1;

    if (bus.intack) begin
      cnt_d[5] = 1'b0;
      if (!irq_set) irq_d = 1'b0;
    end

    if (ga_wr && bus.dout[7:6] == 2'b10 && bus.dout[4]) begin
      cnt_d     = 6'd0;
      irq_d     = 1'b0;
      vs_arm_d  = 1'b0;
      vs_line_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q       <= 2'd1;
      pend_mode_q  <= 2'd1;
      border_q     <= 5'd20;
      border_sel_q <= 1'b0;
      pen_q        <= 4'd0;
      palix_q      <= 4'd0;
      paldat_q     <= 5'd0;
      palwr_q      <= 1'b0;
      hmax_q       <= 6'd40;
      vmax_q       <= 5'd25;
      ma_q         <= 16'h3000;
      crtc_idx_q   <= 5'd0;
      lromdis_q    <= 1'b0;
      uromdis_q    <= 1'b0;
      irq_q        <= 1'b0;
      cnt_q        <= 6'd0;
      vs_arm_q     <= 1'b0;
      vs_line_q    <= 1'b0;
      hsyn_q       <= 1'b1;
      dvsyn_q      <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pend_mode_q  <= pend_mode_d;
      border_q     <= border_d;
      border_sel_q <= border_sel_d;
      pen_q        <= pen_d;
      palix_q      <= palix_d;
      paldat_q     <= paldat_d;
      palwr_q      <= palwr_d;
      hmax_q       <= hmax_d;
      vmax_q       <= vmax_d;
      ma_q         <= ma_d;
      crtc_idx_q   <= crtc_idx_d;
      lromdis_q    <= lromdis_d;
      uromdis_q    <= uromdis_d;
      irq_q        <= irq_d;
      cnt_q        <= cnt_d;
      vs_arm_q     <= vs_arm_d;
      vs_line_q    <= vs_line_d;
      hsyn_q       <= hsyn_d;
      dvsyn_q      <= dvsyn_d;
    end
  end

  assign mode    = mode_q;
  assign border  = border_q;
  assign palix   = palix_q;
  assign paldat  = paldat_q;
  assign palwr   = palwr_q;
  assign hmax    = hmax_q;
  assign vmax    = vmax_q;
  assign ma      = ma_q;
  assign lromdis = lromdis_q;
  assign uromdis = uromdis_q;
  assign bus.irq = irq_q;

endmodule

// File: tb/tb_cpc_gate_array.sv
// Bench for cpc_gate_array: directed scenarios plus random traffic, every
// cycle compared against a behavioural model of the gate array.
module tb_cpc_gate_array;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic hsyn = 1'b1, n64u = 1'b0, dvsyn = 1'b0;
  logic [1:0] mode;
  logic [4:0] border, paldat, vmax;
  logic [3:0] palix;
  logic       palwr, lromdis, uromdis;
  logic [5:0] hmax;
  logic [15:0] ma;

  cpc_gate_array_if bus();

  cpc_gate_array dut (
    .clk(clk), .rstn(rstn), .bus(bus), .hsyn(hsyn), .n64u(n64u), .dvsyn(dvsyn),
    .mode(mode), .border(border), .palix(palix), .paldat(paldat), .palwr(palwr),
    .hmax(hmax), .vmax(vmax), .ma(ma), .lromdis(lromdis), .uromdis(uromdis)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] RST_VEC = {17'd0, 2'd1, 5'd20, 4'd0, 5'd0, 1'b0, 6'd40,
                                     5'd25, 16'h3000, 1'b0, 1'b0, 1'b0};

  // Behavioural reference state
  bit [1:0]  m_mode, m_pend;
  bit [4:0]  m_border, m_paldat, m_idx, m_vmax;
  bit [3:0]  m_pen, m_palix;
  bit        m_bsel, m_palwr, m_lrom, m_urom, m_irq, m_hs, m_dv;
  bit [5:0]  m_hmax;
  bit [15:0] m_ma;
  int        m_cnt, m_vs_left;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {17'd0, mode, border, palix, paldat, palwr, hmax, vmax, ma, lromdis, uromdis, bus.irq};
  endfunction

  function automatic logic [63:0] model_vec();
    return {17'd0, m_mode, m_border, m_palix, m_paldat, m_palwr, m_hmax, m_vmax, m_ma,
            m_lrom, m_urom, m_irq};
  endfunction

  task automatic model_reset();
    m_mode = 2'd1; m_pend = 2'd1; m_border = 5'd20; m_bsel = 1'b0; m_pen = 4'd0;
    m_palix = 4'd0; m_paldat = 5'd0; m_palwr = 1'b0; m_hmax = 6'd40; m_vmax = 5'd25;
    m_ma = 16'h3000; m_idx = 5'd0; m_lrom = 1'b0; m_urom = 1'b0; m_irq = 1'b0;
    m_cnt = 0; m_vs_left = 0; m_hs = 1'b1; m_dv = 1'b0;
  endtask

  // Applies one clock worth of the documented rules to the model, using the inputs now driven.
  task automatic model_step();
    bit ga, hfall, drise, setirq;
    int old, v;
    logic [15:0] a;
    logic [7:0] d;
    a = bus.addr; d = bus.dout;
    ga = bus.iowr && (a[15:14] == 2'b01);
    hfall = m_hs && !hsyn;
    drise = dvsyn && !m_dv;
    m_palwr = 1'b0;
    if (hfall) m_mode = m_pend;
    if (ga && d[7:6] == 2'b00) begin
      if (d[4]) m_bsel = 1'b1;
      else begin m_pen = d[3:0]; m_bsel = 1'b0; end
    end else if (ga && d[7:6] == 2'b01) begin
      if (m_bsel) m_border = d[4:0];
      else begin m_palix = m_pen; m_paldat = d[4:0]; m_palwr = 1'b1; end
    end else if (ga && d[7:6] == 2'b10) begin
      m_lrom = d[2]; m_urom = d[3]; m_pend = d[1:0];
    end
    if (bus.iowr && !a[14]) begin
      v = int'(d);
      if (a[9:8] == 2'b00) m_idx = d[4:0];
      else if (a[9:8] == 2'b01) begin
        if (m_idx == 5'd1) m_hmax = 6'((v > 40) ? 40 : v);
        else if (m_idx == 5'd6) m_vmax = 5'((v > 30) ? 30 : v);
        else if (m_idx == 5'd12) m_ma[15:8] = d;
        else if (m_idx == 5'd13) m_ma[7:0] = d;
      end
    end
    setirq = 1'b0;
    if (n64u) begin
      old = m_cnt;
      m_cnt = (old == 51) ? 0 : old + 1;
      if (old == 51) setirq = 1'b1;
      if (m_vs_left > 0 && !drise) begin
        m_vs_left--;
        if (m_vs_left == 0) begin
          m_cnt = 0;
          if (old >= 32) setirq = 1'b1;
        end
      end
    end
    if (drise) m_vs_left = 2;
    if (setirq) m_irq = 1'b1;
    if (bus.intack) begin
      if (m_cnt >= 32) m_cnt -= 32;
      if (!setirq) m_irq = 1'b0;
    end
    if (ga && d[7:6] == 2'b10 && d[4]) begin
      m_cnt = 0; m_irq = 1'b0; m_vs_left = 0;
    end
    m_hs = hsyn; m_dv = dvsyn;
  endtask

  // Called at a falling edge with inputs driven; advances one cycle and compares.
  task automatic tick();
    model_step();
    @(negedge clk);
    check("cycle", dut_vec(), model_vec());
    bus.iowr = 1'b0; bus.intack = 1'b0; n64u = 1'b0;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a; bus.dout = d; bus.iowr = 1'b1;
    tick();
  endtask

  task automatic lines(input int n);
    repeat (n) begin n64u = 1'b1; tick(); end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    int sel;
    bus.addr = 16'h0; bus.dout = 8'h0; bus.iowr = 1'b0; bus.intack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), RST_VEC);
    model_reset();
    rstn = 1'b1;

    // Palette write through a pen
    io_wr(16'h7F00, 8'h03);
    io_wr(16'h7F00, 8'h4A);
    check("pal_wr", {palix, paldat, palwr}, {4'd3, 5'd10, 1'b1});
    tick();
    check("pal_wr_end", palwr, 1'b0);

    // Border write, no palette pulse
    io_wr(16'h7F00, 8'h10);
    io_wr(16'h7F00, 8'h45);
    check("border_5", {border, palwr}, {5'd5, 1'b0});
    io_wr(16'h7F00, 8'h54);
    check("border_20", {border, palwr}, {5'd20, 1'b0});

    // Config: ROM bits immediate, mode deferred to hsyn fall
    io_wr(16'h7F00, 8'h8A);
    check("cfg_rom", {lromdis, uromdis, mode}, {1'b0, 1'b1, 2'd1});
    tick(); tick();
    check("mode_hold", mode, 2'd1);
    hsyn = 1'b0; tick();
    check("mode_switch", mode, 2'd2);
    hsyn = 1'b1;
    io_wr(16'h7F00, 8'h81);
    io_wr(16'h7F00, 8'h80);
    hsyn = 1'b0; tick();
    check("mode_last_wins", mode, 2'd0);
    hsyn = 1'b1;
    io_wr(16'h7F00, 8'hC5);
    check("ignored_11", {border, lromdis, uromdis}, {5'd20, 1'b0, 1'b0});

    // CRTC shadow registers
    io_wr(16'hBC00, 8'd1);  io_wr(16'hBD00, 8'd50);
    check("hmax_sat", hmax, 6'd40);
    io_wr(16'hBD00, 8'd25);
    check("hmax_25", hmax, 6'd25);
    io_wr(16'hBC00, 8'd6);  io_wr(16'hBD00, 8'd99);
    check("vmax_sat", vmax, 5'd30);
    io_wr(16'hBC00, 8'd12); io_wr(16'hBD00, 8'h20);
    io_wr(16'hBC00, 8'd13); io_wr(16'hBD00, 8'h5A);
    check("ma", ma, 16'h205A);
    io_wr(16'hBE00, 8'h77);
    check("crtc_ignored", ma, 16'h205A);

    // 52-line interrupt and acknowledge
    io_wr(16'h7F00, 8'h90);
    lines(51);
    check("irq_51", bus.irq, 1'b0);
    lines(1);
    check("irq_52", bus.irq, 1'b1);
    tick(); tick();
    check("irq_held", bus.irq, 1'b1);
    bus.intack = 1'b1; tick();
    check("irq_ack", bus.irq, 1'b0);
    lines(51);
    check("cnt_zero_51", bus.irq, 1'b0);
    lines(1);
    check("cnt_zero_52", bus.irq, 1'b1);
    bus.intack = 1'b1; tick();
    lines(51);
    n64u = 1'b1; bus.intack = 1'b1; tick();
    check("ack_vs_52", bus.irq, 1'b1);
    bus.intack = 1'b1; tick();
    lines(51);
    n64u = 1'b1; io_wr(16'h7F00, 8'h90);
    check("cfg_clr_prio", bus.irq, 1'b0);

    // Vsync resynchronisation
    lines(40);
    dvsyn = 1'b1; tick();
    dvsyn = 1'b0; tick();
    lines(1);
    check("vs_one_line", bus.irq, 1'b0);
    lines(1);
    check("vs_fire_hi", bus.irq, 1'b1);
    bus.intack = 1'b1; tick();
    lines(51);
    check("vs_cnt0_51", bus.irq, 1'b0);
    lines(1);
    check("vs_cnt0_52", bus.irq, 1'b1);
    io_wr(16'h7F00, 8'h90);
    lines(20);
    dvsyn = 1'b1; tick();
    dvsyn = 1'b0; tick();
    lines(2);
    check("vs_fire_lo", bus.irq, 1'b0);
    lines(51);
    check("vs_lo_cnt0", bus.irq, 1'b0);
    lines(1);
    check("vs_lo_cnt52", bus.irq, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) begin
        sel = $urandom_range(4);
        rd = 8'($urandom);
        if (rd[7:6] == 2'b10 && rd[4] && $urandom_range(7) != 0) rd[4] = 1'b0;
        case (sel)
          0: bus.addr = 16'h7F00;
          1: bus.addr = 16'hBC00;
          2: bus.addr = 16'hBD00;
          3: bus.addr = 16'hBE00;
          default: bus.addr = 16'($urandom);
        endcase
        if (sel == 1) rd = ($urandom_range(1) == 0) ? 8'(1 + 5 * $urandom_range(1)) : 8'(12 + $urandom_range(1));
        bus.dout = rd; bus.iowr = 1'b1;
      end
      n64u = ($urandom_range(2) == 0);
      if (!n64u && $urandom_range(19) == 0) bus.intack = 1'b1;
      if (!n64u && $urandom_range(39) == 0) dvsyn = ~dvsyn;
      if ($urandom_range(7) == 0) hsyn = ~hsyn;
      tick();
    end

    // Reset mid-operation cancels palwr pulse and pending mode
    hsyn = 1'b1; tick();
    io_wr(16'h7F00, 8'h80);
    io_wr(16'h7F00, 8'h02);
    bus.addr = 16'h7F00; bus.dout = 8'h4F; bus.iowr = 1'b1;
    @(posedge clk); #1;
    check("palwr_before_rst", palwr, 1'b1);
    bus.iowr = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_async", dut_vec(), RST_VEC);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    hsyn = 1'b0; tick();
    check("mode_after_rst", mode, 2'd1);
    hsyn = 1'b1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
